// File: rtl/dpram_bist_pkg.sv
// dpram_bist_pkg: shared FSM states, counter width and address-derived pattern for the RAM BIST.
package dpram_bist_pkg;
  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, CHECK, DONE} state_e;
  localparam int ERR_W = 16;
  function automatic logic [31:0] pattern(input logic [31:0] a, input logic [31:0] seed);
    return a ^ seed;
  endfunction
endpackage

// File: rtl/dpram_bist_cmp.sv
// dpram_bist_cmp: one-deep read compare stage with first-fail capture and saturating error count.
module dpram_bist_cmp
  import dpram_bist_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             issue_i,
  input  logic [AW-1:0]    issue_addr_i,
  input  logic [DW-1:0]    issue_exp_i,
  input  logic [DW-1:0]    rdata_i,
  output logic             mismatch_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [AW-1:0]    fail_addr_o,
  output logic [DW-1:0]    fail_data_o,
  output logic [DW-1:0]    fail_expected_o
);
  logic             valid_q;
  logic [DW-1:0]    exp_q, fd_q, fe_q;
  logic [AW-1:0]    addr_q, fa_q;
  logic [ERR_W-1:0] err_q;
  assign mismatch_o      = valid_q && (rdata_i != exp_q);
  assign err_count_o     = err_q;
  assign fail_addr_o     = fa_q;
  assign fail_data_o     = fd_q;
  assign fail_expected_o = fe_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      exp_q   <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
      fe_q    <= '0;
    end else begin
      valid_q <= issue_i;
      exp_q   <= issue_exp_i;
      addr_q  <= issue_addr_i;
      if (clr_i) begin
        err_q <= '0;
        fa_q  <= '0;
        fd_q  <= '0;
        fe_q  <= '0;
      end else if (mismatch_o) begin
        if (err_q == '0) begin
          fa_q <= addr_q;
          fd_q <= rdata_i;
          fe_q <= exp_q;
        end
        if (err_q != '1) err_q <= err_q + ERR_W'(1);
      end
    end
  end
endmodule

// File: rtl/dpram_bist.sv
// dpram_bist: write/read-back BIST for a dual-port RAM (P then ~P patterns).
// Define DPRAM_BIST_NOSTOP_EN to run all phases to completion instead of stopping at the first mismatch.
module dpram_bist
  import dpram_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MEM_LENGTH = 64,
  parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5,
  localparam int                   AW         = $clog2(MEM_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [AW-1:0]         fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic                  ram_wen_a,
  output logic [AW-1:0]         ram_write_address_a,
  output logic [DATA_WIDTH-1:0] ram_data_in_a,
  output logic [AW-1:0]         ram_read_address_b,
  input  logic [DATA_WIDTH-1:0] ram_data_out_b
);
  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  pass_q, pass_d;
  logic                  wr, rd, last, accept, mismatch, abort;
  logic [DATA_WIDTH-1:0] pat, exp_w;
  assign wr     = state_q inside {WR0, WR1};
  assign rd     = state_q inside {RD0, RD1};
  assign last   = addr_q == AW'(MEM_LENGTH - 1);
  assign accept = start && (state_q inside {IDLE, DONE});
  assign pat    = DATA_WIDTH'(pattern(32'(addr_q), 32'(SEED)));
  assign exp_w  = (state_q inside {WR1, RD1}) ? ~pat : pat;
`ifdef DPRAM_BIST_NOSTOP_EN
  assign abort = 1'b0;
`else
  assign abort = mismatch;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = (wr || rd) ? (last ? '0 : addr_q + AW'(1)) : '0;
    case (state_q)
      IDLE, DONE: state_d = accept ? WR0 : state_q;
      WR0:        state_d = last ? RD0 : WR0;
      RD0:        state_d = last ? WR1 : RD0;
      WR1:        state_d = last ? RD1 : WR1;
      RD1:        state_d = last ? CHECK : RD1;
      CHECK:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (abort) begin
      state_d = DONE;
      addr_d  = '0;
    end
    pass_d = accept ? 1'b0 :
             (state_d == DONE && state_q != DONE) ? (err_count == '0 && !mismatch) : pass_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
    end
  end
  assign busy                = !(state_q inside {IDLE, DONE});
  assign done                = state_q == DONE;
  assign pass                = pass_q;
  assign ram_wen_a           = wr;
  assign ram_write_address_a = wr ? addr_q : '0;
  assign ram_data_in_a       = wr ? exp_w : '0;
  assign ram_read_address_b  = rd ? addr_q : '0;
  dpram_bist_cmp #(.DW(DATA_WIDTH), .AW(AW)) u_cmp (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (accept),
    .issue_i        (rd && !abort),
    .issue_addr_i   (addr_q),
    .issue_exp_i    (exp_w),
    .rdata_i        (ram_data_out_b),
    .mismatch_o     (mismatch),
    .err_count_o    (err_count),
    .fail_addr_o    (fail_addr),
    .fail_data_o    (fail_data),
    .fail_expected_o(fail_expected)
  );
endmodule
